// File: rtl/pci_initiator.sv
// -----------------------------------------------------------------------------
// pci_initiator
//   Bus-master side of the shared PCI-style bus. Requests the bus on REQ,
//   waits for GNT with FRAME/IRDY idle, runs one address phase and then a
//   burst of 1..MAX_BURST data phases paced by TRDY. Ends with a one-cycle
//   turnaround that pulses done, or abort when no target claimed the cycle
//   within DEVSEL_TIMEOUT data-phase cycles (master abort).
//
// Ports
//   clk, rst_n                 bus clock, synchronous active-low reset
//   start/cmd/addr/len         local command (accepted only while busy=0)
//   wr_data/wr_pop             show-ahead write word and its consume pulse
//   rd_data/rd_valid           captured read word and its valid pulse
//   busy/done/abort            transaction status
//   REQ/GNT                    arbitration handshake (active low)
//   FRAME_in/IRDY_in           sampled bus state (active low)
//   TRDY/DEVSEL                target ready / claim (active low)
//   FRAME_o/IRDY_o/C_BE_o      driven control, enabled by ctl_oe
//   AD_o/AD_oe/AD_i            address/data bus
// -----------------------------------------------------------------------------
module pci_initiator #(
    parameter int MAX_BURST      = 8,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        REQ,
    input  logic        GNT,
    input  logic        FRAME_in,
    input  logic        IRDY_in,
    input  logic        TRDY,
    input  logic        DEVSEL,
    output logic        FRAME_o,
    output logic        IRDY_o,
    output logic        ctl_oe,
    output logic [3:0]  C_BE_o,
    output logic [31:0] AD_o,
    output logic        AD_oe,
    input  logic [31:0] AD_i
);

    localparam int RW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_TURN
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cmd_q, cmd_n;
    logic [31:0]   addr_q, addr_n;
    logic [RW-1:0] rem_q, rem_n;
    logic [CW-1:0] dcnt_q, dcnt_n;
    logic          mab_q, mab_n;        // in the FRAME-release cycle of a master abort
    logic          aborted_q, aborted_n;
    logic [31:0]   rd_data_q;
    logic          rd_valid_q;

    logic [RW-1:0] eff_len;
    logic          is_write;
    logic          last;
    logic          xfer;

    always_comb begin
        if (len == 4'd0)
            eff_len = RW'(1);
        else if (int'(len) > MAX_BURST)
            eff_len = RW'(MAX_BURST);
        else
            eff_len = RW'(len);
    end

    assign is_write = cmd_q[0];
    assign last     = (rem_q == RW'(1));
    // A data phase completes when the target is both claiming and ready.
    assign xfer     = (state == S_DATA) && !mab_q && !TRDY && !DEVSEL;

    // Next-state and output decode. Outputs are decoded from registered
    // state only, except wr_pop and write-phase AD_o, which follow the
    // show-ahead write word so a zero-wait burst can advance every cycle.
    always_comb begin
        state_n   = state;
        cmd_n     = cmd_q;
        addr_n    = addr_q;
        rem_n     = rem_q;
        dcnt_n    = dcnt_q;
        mab_n     = mab_q;
        aborted_n = aborted_q;

        REQ     = 1'b1;
        FRAME_o = 1'b1;
        IRDY_o  = 1'b1;
        ctl_oe  = 1'b0;
        C_BE_o  = 4'hF;
        AD_o    = '0;
        AD_oe   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        wr_pop  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cmd_n     = cmd;
                    addr_n    = addr;
                    rem_n     = eff_len;
                    dcnt_n    = '0;
                    mab_n     = 1'b0;
                    aborted_n = 1'b0;
                    state_n   = S_REQ;
                end
            end

            S_REQ: begin
                busy = 1'b1;
                REQ  = 1'b0;
                if (!GNT && FRAME_in && IRDY_in)
                    state_n = S_ADDR;
            end

            S_ADDR: begin
                busy    = 1'b1;
                FRAME_o = 1'b0;
                ctl_oe  = 1'b1;
                C_BE_o  = cmd_q;
                AD_o    = addr_q;
                AD_oe   = 1'b1;
                dcnt_n  = '0;
                state_n = S_DATA;
            end

            S_DATA: begin
                busy    = 1'b1;
                ctl_oe  = 1'b1;
                IRDY_o  = 1'b0;
                C_BE_o  = 4'h0;
                FRAME_o = mab_q || last;
                AD_oe   = is_write;
                AD_o    = is_write ? wr_data : '0;
                wr_pop  = xfer && is_write;
                if (mab_q) begin
                    state_n = S_TURN;
                end else if (xfer) begin
                    rem_n  = rem_q - RW'(1);
                    dcnt_n = '0;
                    if (last)
                        state_n = S_TURN;
                end else if (DEVSEL) begin
                    if (dcnt_q == CW'(DEVSEL_TIMEOUT - 1)) begin
                        aborted_n = 1'b1;
                        // FRAME still asserted: release it for one cycle first.
                        if (last)
                            state_n = S_TURN;
                        else
                            mab_n = 1'b1;
                    end else begin
                        dcnt_n = dcnt_q + CW'(1);
                    end
                end else begin
                    dcnt_n = '0;
                end
            end

            S_TURN: begin
                busy    = 1'b1;
                ctl_oe  = 1'b1;
                done    = !aborted_q;
                abort   = aborted_q;
                mab_n   = 1'b0;
                state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            dcnt_q     <= '0;
            mab_q      <= 1'b0;
            aborted_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_n;
            cmd_q      <= cmd_n;
            addr_q     <= addr_n;
            rem_q      <= rem_n;
            dcnt_q     <= dcnt_n;
            mab_q      <= mab_n;
            aborted_q  <= aborted_n;
            rd_valid_q <= xfer && !is_write;
            if (xfer && !is_write)
                rd_data_q <= AD_i;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pci_initiator.sv
// -----------------------------------------------------------------------------
// tb_pci_initiator
//   Directed bench for pci_initiator: a per-cycle vector table for a single
//   write and a read burst with a wait state, plus hand-written sequences for
//   arbitration wait, master abort, length clipping and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_pci_initiator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        abort;
    logic        REQ;
    logic        GNT;
    logic        FRAME_in;
    logic        IRDY_in;
    logic        TRDY;
    logic        DEVSEL;
    logic        FRAME_o;
    logic        IRDY_o;
    logic        ctl_oe;
    logic [3:0]  C_BE_o;
    logic [31:0] AD_o;
    logic        AD_oe;
    logic [31:0] AD_i;

    int n_chk  = 0;
    int n_fail = 0;

    pci_initiator #(.MAX_BURST(8), .DEVSEL_TIMEOUT(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr),
        .len(len), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort),
        .REQ(REQ), .GNT(GNT), .FRAME_in(FRAME_in), .IRDY_in(IRDY_in),
        .TRDY(TRDY), .DEVSEL(DEVSEL), .FRAME_o(FRAME_o), .IRDY_o(IRDY_o),
        .ctl_oe(ctl_oe), .C_BE_o(C_BE_o), .AD_o(AD_o), .AD_oe(AD_oe),
        .AD_i(AD_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        gnt;
        logic        trdy;
        logic [31:0] ad_i;
        logic        req;
        logic        frame;
        logic        irdy;
        logic        ctl_oe;
        logic        ad_oe;
        logic [31:0] ad;
        logic [3:0]  cbe;
        logic        busy;
        logic        done;
        logic        abort;
        logic        pop;
        logic        rdv;
        logic [31:0] rdd;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".REQ"},      32'(REQ),      32'd1);
        chk({tag, ".FRAME_o"},  32'(FRAME_o),  32'd1);
        chk({tag, ".IRDY_o"},   32'(IRDY_o),   32'd1);
        chk({tag, ".ctl_oe"},   32'(ctl_oe),   32'd0);
        chk({tag, ".AD_oe"},    32'(AD_oe),    32'd0);
        chk({tag, ".AD_o"},     AD_o,          32'd0);
        chk({tag, ".C_BE_o"},   32'(C_BE_o),   32'hF);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".abort"},    32'(abort),    32'd0);
        chk({tag, ".wr_pop"},   32'(wr_pop),   32'd0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, ".rd_data"},  rd_data,       32'd0);
    endtask

    // Runs the current transaction to completion (bounded). Models a
    // show-ahead write FIFO whose words are 0xC0000000 + index.
    task automatic wait_end(input string tag, input int bound,
                            output int pops, output int rdvs, output int dph,
                            output bit gd, output bit ga);
        bit fin;
        bit popped;
        fin = 1'b0; popped = 1'b0;
        pops = 0; rdvs = 0; dph = 0; gd = 1'b0; ga = 1'b0;
        for (int k = 0; k < bound && !fin; k++) begin
            tick();
            start = 1'b0;
            if (popped) wr_data = wr_data + 32'd1;
            popped = 1'b0;
            #2;
            if (busy && !IRDY_o && !FRAME_o) dph++;
            else if (busy && !IRDY_o && FRAME_o && !abort) dph++;
            if (wr_pop) begin
                chk($sformatf("%s.wdata%0d", tag, pops), AD_o, 32'hC000_0000 + 32'(pops));
                pops++;
                popped = 1'b1;
            end
            if (rd_valid) rdvs++;
            if (done) gd = 1'b1;
            if (abort) ga = 1'b1;
            fin = done || abort;
        end
        chk({tag, ".complete"}, 32'(fin), 32'd1);
    endtask

    task automatic run_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                           input logic [3:0] l,
                           output int pops, output int rdvs, output int dph,
                           output bit gd, output bit ga);
        tick();
        wr_data = 32'hC000_0000;
        start = 1'b1; cmd = c; addr = a; len = l;
        #2;
        wait_end(tag, 60, pops, rdvs, dph, gd, ga);
    endtask

    initial begin
        int pops, rdvs, dph;
        bit gd, ga;

        // Single write then a 4-phase read with a TRDY wait on phase 2.
        // Columns: start cmd addr len gnt trdy ad_i | req frame irdy oe ad_oe ad cbe | busy done abort pop rdv rdd
        tbl[0]  = '{1'b1, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000,     4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD0001, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 4'h7, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b1, 32'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
        tbl[11] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0};
        tbl[12] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1};
        tbl[13] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2};
        tbl[14] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA3};
        tbl[15] = '{1'b0, 4'h6, 32'h2000, 4'd4, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA3};

        rst_n = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; len = 4'd0;
        wr_data = 32'hDEAD0001; GNT = 1'b0; FRAME_in = 1'b1; IRDY_in = 1'b1;
        TRDY = 1'b0; DEVSEL = 1'b0; AD_i = 32'h0;
        tick();
        tick();
        #2;
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tick();
            start = tbl[i].start; cmd = tbl[i].cmd; addr = tbl[i].addr; len = tbl[i].len;
            GNT = tbl[i].gnt; TRDY = tbl[i].trdy; AD_i = tbl[i].ad_i;
            #2;
            chk($sformatf("row%0d.REQ", i),      32'(REQ),      32'(tbl[i].req));
            chk($sformatf("row%0d.FRAME_o", i),  32'(FRAME_o),  32'(tbl[i].frame));
            chk($sformatf("row%0d.IRDY_o", i),   32'(IRDY_o),   32'(tbl[i].irdy));
            chk($sformatf("row%0d.ctl_oe", i),   32'(ctl_oe),   32'(tbl[i].ctl_oe));
            chk($sformatf("row%0d.AD_oe", i),    32'(AD_oe),    32'(tbl[i].ad_oe));
            if (tbl[i].ad_oe)
                chk($sformatf("row%0d.AD_o", i), AD_o, tbl[i].ad);
            chk($sformatf("row%0d.C_BE_o", i),   32'(C_BE_o),   32'(tbl[i].cbe));
            chk($sformatf("row%0d.busy", i),     32'(busy),     32'(tbl[i].busy));
            chk($sformatf("row%0d.done", i),     32'(done),     32'(tbl[i].done));
            chk($sformatf("row%0d.abort", i),    32'(abort),    32'(tbl[i].abort));
            chk($sformatf("row%0d.wr_pop", i),   32'(wr_pop),   32'(tbl[i].pop));
            chk($sformatf("row%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].rdv));
            chk($sformatf("row%0d.rd_data", i),  rd_data,       tbl[i].rdd);
        end

        // Arbitration wait: no grant for 6 cycles, then grant with a busy bus.
        tick();
        wr_data = 32'hC000_0000;
        GNT = 1'b1; start = 1'b1; cmd = 4'h7; addr = 32'h5000; len = 4'd1;
        #2;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
            if (k >= 6) begin GNT = 1'b0; FRAME_in = 1'b0; end
            #2;
            chk($sformatf("arb%0d.REQ", k),     32'(REQ),     32'd0);
            chk($sformatf("arb%0d.FRAME_o", k), 32'(FRAME_o), 32'd1);
            chk($sformatf("arb%0d.ctl_oe", k),  32'(ctl_oe),  32'd0);
        end
        tick();
        FRAME_in = 1'b1;
        #2;
        chk("arb_idle.REQ", 32'(REQ), 32'd0);
        tick();
        #2;
        chk("arb_addr.FRAME_o", 32'(FRAME_o), 32'd0);
        chk("arb_addr.REQ",     32'(REQ),     32'd1);
        chk("arb_addr.AD_o",    AD_o,         32'h5000);
        wait_end("arb", 20, pops, rdvs, dph, gd, ga);
        chk("arb.done", 32'(gd), 32'd1);
        chk("arb.pops", 32'(pops), 32'd1);

        // Master abort: read of 3 with DEVSEL never asserted.
        tick();
        DEVSEL = 1'b1; TRDY = 1'b0;
        start = 1'b1; cmd = 4'h6; addr = 32'h6000; len = 4'd3;
        #2;
        tick(); start = 1'b0; #2;
        chk("mab_req.REQ", 32'(REQ), 32'd0);
        tick(); #2;
        chk("mab_addr.FRAME_o", 32'(FRAME_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick(); #2;
            chk($sformatf("mab_d%0d.FRAME_o", k),  32'(FRAME_o),  32'd0);
            chk($sformatf("mab_d%0d.IRDY_o", k),   32'(IRDY_o),   32'd0);
            chk($sformatf("mab_d%0d.rd_valid", k), 32'(rd_valid), 32'd0);
        end
        tick(); #2;
        chk("mab_rel.FRAME_o",  32'(FRAME_o),  32'd1);
        chk("mab_rel.IRDY_o",   32'(IRDY_o),   32'd0);
        chk("mab_rel.rd_valid", 32'(rd_valid), 32'd0);
        chk("mab_rel.abort",    32'(abort),    32'd0);
        tick(); #2;
        chk("mab_turn.abort",   32'(abort),    32'd1);
        chk("mab_turn.done",    32'(done),     32'd0);
        chk("mab_turn.IRDY_o",  32'(IRDY_o),   32'd1);
        chk("mab_turn.rd_valid",32'(rd_valid), 32'd0);
        tick(); #2;
        chk("mab_idle.busy",    32'(busy),     32'd0);
        chk("mab_idle.abort",   32'(abort),    32'd0);
        DEVSEL = 1'b0;

        // Length edges.
        run_txn("len0", 4'h7, 32'h3000, 4'd0, pops, rdvs, dph, gd, ga);
        chk("len0.pops",   32'(pops), 32'd1);
        chk("len0.phases", 32'(dph),  32'd1);
        chk("len0.done",   32'(gd),   32'd1);
        run_txn("len12", 4'h7, 32'h3100, 4'd12, pops, rdvs, dph, gd, ga);
        chk("len12.pops",   32'(pops), 32'd8);
        chk("len12.phases", 32'(dph),  32'd8);
        chk("len12.done",   32'(gd),   32'd1);

        // Reset during the 2nd of 4 write data phases.
        tick();
        wr_data = 32'hC000_0000;
        start = 1'b1; cmd = 4'h7; addr = 32'h4000; len = 4'd4;
        #2;
        tick(); start = 1'b0; #2;   // REQ
        tick(); #2;                 // ADDR
        tick(); #2;                 // DATA 1
        chk("rst_d1.wr_pop", 32'(wr_pop), 32'd1);
        tick();
        wr_data = 32'hC000_0001;
        rst_n = 1'b0;               // DATA 2
        #2;
        tick(); #2;
        check_reset("rst_mid");
        rst_n = 1'b1;
        run_txn("after_rst", 4'h7, 32'h4100, 4'd2, pops, rdvs, dph, gd, ga);
        chk("after_rst.pops",  32'(pops), 32'd2);
        chk("after_rst.done",  32'(gd),   32'd1);
        chk("after_rst.abort", 32'(ga),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pci_initiator.md
# pci_initiator

Bus-master (initiator) side of the shared PCI-style bus whose arbitration is handled by the 8-way arbiter. It requests the bus on REQ, waits for GNT with the bus idle, and runs one address phase followed by a burst of 1..MAX_BURST data phases. Data phases are paced by TRDY wait states. It terminates cleanly, or by master abort when no target claims the cycle. It sits between a local command/data port and the bus pins, one instance per requesting agent.

## Interface
- MAX_BURST, 8: maximum data phases per transaction (len clipped to this).
- DEVSEL_TIMEOUT, 5: data-phase cycles without DEVSEL before master abort.
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; accepted only when busy=0.
- cmd  in  4  bus command; cmd[0]=1 write, 0 read.
- addr  in  32  start address.
- len  in  4  data phases; 0 treated as 1; >MAX_BURST clipped.
- wr_data  in  32  show-ahead write word; must be valid while busy on writes.
- wr_pop  out  1  pulse: current wr_data consumed.
- rd_data  out  32  captured read word.
- rd_valid  out  1  pulse: rd_data valid.
- busy  out  1  transaction in progress.
- done  out  1  pulse at normal completion.
- abort  out  1  pulse at master-abort completion.
- REQ  out  1  bus request, active low.
- GNT  in  1  grant for this agent, active low.
- FRAME_in, IRDY_in  in  1 each  sampled bus FRAME/IRDY, active low.
- TRDY, DEVSEL  in  1 each  target ready/claim, active low.
- FRAME_o, IRDY_o  out  1 each  driven FRAME/IRDY, active low.
- ctl_oe  out  1  enable for FRAME_o/IRDY_o/C_BE_o.
- C_BE_o  out  4  command in address phase, byte enables (4'b0000) in data phases.
- AD_o  out  32  address/write data.
- AD_oe  out  1  AD output enable.
- AD_i  in  32  sampled AD for reads.

## Operation
- States: IDLE, REQ, ADDR, DATA, TURN.
- IDLE: all outputs at reset values. start=1 latches cmd, addr, effective len; next state REQ; busy=1.
- REQ: REQ=0. Leave when GNT=0 and FRAME_in=1 and IRDY_in=1 are all sampled together; otherwise stay indefinitely.
- ADDR (one cycle): REQ=1, FRAME_o=0, IRDY_o=1, ctl_oe=1, AD_o=addr, AD_oe=1, C_BE_o=cmd.
- DATA: IRDY_o=0 and C_BE_o=0000.
  - Write: AD_oe=1, AD_o=wr_data.
  - Read: AD_oe=0.
  - FRAME_o=0 while remaining>1; FRAME_o=1 when remaining==1 (last phase).
- Transfer: occurs at an edge in DATA where TRDY=0 and DEVSEL=0 are sampled.
  - Write: wr_pop=1 for that cycle.
  - Read: rd_data<=AD_i, rd_valid=1 next cycle.
  - remaining decrements. On the last transfer go to TURN.
- Master abort: DEVSEL=1 for DEVSEL_TIMEOUT consecutive DATA cycles.
  - If FRAME_o=0: one cycle with FRAME_o=1, IRDY_o=0, then TURN.
  - TURN raises abort=1 instead of done. No wr_pop/rd_valid occurs for the aborted phase.
- TURN (one cycle): FRAME_o=1, IRDY_o=1, ctl_oe=1 (drive high), AD_oe=0; done or abort=1. Next state IDLE, busy=0.
- GNT deasserted during ADDR/DATA is ignored (no latency timer). start while busy is ignored.
- Reset value of every output (rst_n=0 at any edge, any state): REQ=1, FRAME_o=1, IRDY_o=1, ctl_oe=0, AD_oe=0, AD_o=0, C_BE_o=4'hF, busy=0, done=0, abort=0, wr_pop=0, rd_valid=0, rd_data=0. Reset aborts any transaction silently with no done/abort pulse.

## Timing
- Registered outputs; changes appear one cycle after the sampled condition.
- Zero-wait single write, GNT already 0 and bus idle, start at edge 0:
  - REQ state cycle 1.
  - ADDR cycle 2.
  - DATA cycle 3 (FRAME_o=1, IRDY_o=0).
  - TURN cycle 4 (done).
  - IDLE cycle 5.
- Burst of N with zero waits: N consecutive DATA cycles. Each TRDY=1 cycle adds one cycle.
- rd_valid lags the transfer edge by one cycle; wr_pop coincides with the transfer cycle.
- FRAME_o never asserts while FRAME_in or IRDY_in showed a busy bus at the granting edge.

## Test plan
- Single write: cmd=0111, addr=0x1000, len=1, GNT=0, TRDY=DEVSEL=0 -> AD_o=0x1000 in ADDR, one wr_pop, done at cycle 4, busy low at cycle 5.
- Read burst: cmd=0110, len=4, target supplies 0xA0..0xA3 with TRDY=1 on the 2nd phase -> 4 rd_valid pulses carrying 0xA0..0xA3 in order; FRAME_o rises with the 4th phase; 5 DATA cycles total.
- Arbitration wait: GNT=1 for 6 cycles, then GNT=0 with FRAME_in=0 for 2 more cycles -> REQ held 0 throughout; ADDR only after FRAME_in=IRDY_in=1 and GNT=0.
- Master abort: len=3, DEVSEL held 1 -> after 5 DATA cycles FRAME_o=1 for one cycle, then TURN with abort=1; no done, wr_pop or rd_valid.
- Length edges: len=0 -> exactly 1 phase; len=12 -> exactly 8 phases.
- Reset mid-burst: rst_n=0 during the 2nd of 4 data phases -> next cycle all outputs at reset values, no done/abort pulse; a new start afterwards completes normally.
